// File: rtl/row_t2b_if.sv
// Handshake/data bundle for the row thermometer-to-binary encoder.
// The master modport belongs to the producer of sampled row words, and the slave modport belongs to the encoder.
interface row_t2b_if #(
  parameter int N_BITS = 16,
  parameter int CNT_W  = $clog2(N_BITS + 1),
  parameter int ERR_W  = 8
);
  logic              valid_i;
  logic [N_BITS-1:0] data_i;
  logic              oc;
  logic              clr_i;
  logic              valid_o;
  logic [CNT_W-1:0]  data_o;
  logic              bubble_o;
  logic              err_o;
  logic [ERR_W-1:0]  err_cnt_o;

  modport master (
    output valid_i, data_i, oc, clr_i,
    input  valid_o, data_o, bubble_o, err_o, err_cnt_o
  );

  modport slave (
    input  valid_i, data_i, oc, clr_i,
    output valid_o, data_o, bubble_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/row_t2b.sv
// Row thermometer-to-binary encoder: orientation normalize, 3-tap majority bubble
// suppression, popcount and monotonicity check in a 2-stage pipeline, plus a saturating error counter.
module row_t2b #(
  parameter int N_BITS = 16,
  parameter int CNT_W  = $clog2(N_BITS + 1),
  parameter int ERR_W  = 8
) (
  input  logic      clk_i,
  input  logic      rst_i,
  row_t2b_if.slave  bus
);

  logic [N_BITS-1:0] norm;
  logic [N_BITS+1:0] ext;
  logic [N_BITS-1:0] corr;

  logic              s1_valid;
  logic [N_BITS-1:0] s1_c;
  logic              s1_bub;

  logic [CNT_W-1:0]  ones;
  logic              mono;

  // NOTE: every always_comb output gets a default before any conditional logic, so no latch can be inferred.
  always_comb begin
    norm = bus.data_i;
    if (bus.oc) begin
      for (int k = 0; k < N_BITS; k++) norm[k] = bus.data_i[N_BITS-1-k];
    end
  end

  // Virtual guard bits: below bit 0 the row counts as filled, and above the top bit it counts as empty.
  assign ext = {1'b0, norm, 1'b1};

  always_comb begin
    corr = '0;
    for (int k = 0; k < N_BITS; k++) begin
      corr[k] = (ext[k] & ext[k+1]) | (ext[k] & ext[k+2]) | (ext[k+1] & ext[k+2]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_c     <= '0;
      s1_bub   <= 1'b0;
    end else begin
      s1_valid <= bus.valid_i;
      if (bus.valid_i) begin
        s1_c   <= corr;
        s1_bub <= (corr != norm);
      end
    end
  end

  always_comb begin
    ones = '0;
    for (int k = 0; k < N_BITS; k++) ones = ones + CNT_W'(s1_c[k]);
  end

  // A word of the form 0..01..1 plus one is a power of two, or it wraps to zero when all bits are ones.
  assign mono = ((s1_c & (s1_c + N_BITS'(1))) == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.valid_o  <= 1'b0;
      bus.data_o   <= '0;
      bus.bubble_o <= 1'b0;
      bus.err_o    <= 1'b0;
    end else begin
      bus.valid_o <= s1_valid;
      if (s1_valid) begin
        bus.data_o   <= ones;
        bus.bubble_o <= s1_bub;
        bus.err_o    <= ~mono;
      end
    end
  end

  // Clear wins over a simultaneous increment, and the count sticks at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.err_cnt_o <= '0;
    end else if (bus.clr_i) begin
      bus.err_cnt_o <= '0;
    end else if (bus.valid_o && bus.err_o && (bus.err_cnt_o != '1)) begin
      bus.err_cnt_o <= bus.err_cnt_o + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_row_t2b.sv
// Directed bench for row_t2b: a vector table for streaming decode, plus hand sequences
// for error-counter saturation and clear, and for reset while words are in flight.
module tb_row_t2b;

  localparam int N_BITS = 16;
  localparam int CNT_W  = 5;
  localparam int ERR_W  = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  row_t2b_if #(.N_BITS(N_BITS), .CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

  row_t2b #(.N_BITS(N_BITS), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic              v;
    logic              oc;
    logic [N_BITS-1:0] data;
    logic [CNT_W-1:0]  exp_data;
    logic              exp_bub;
    logic              exp_err;
  } vec_t;

  localparam int NV = 13;
  vec_t vec [NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic oc, input logic [N_BITS-1:0] d);
    bus.valid_i = v;
    bus.oc      = oc;
    bus.data_i  = d;
  endtask

  initial begin
    // Idle rows carry the value that data_o must keep holding.
    vec[0]  = '{1'b1, 1'b0, 16'h0000, 5'd0,  1'b0, 1'b0};
    vec[1]  = '{1'b1, 1'b0, 16'h0001, 5'd1,  1'b0, 1'b0};
    vec[2]  = '{1'b1, 1'b0, 16'h00FF, 5'd8,  1'b0, 1'b0};
    vec[3]  = '{1'b1, 1'b0, 16'hFFFF, 5'd16, 1'b0, 1'b0};
    vec[4]  = '{1'b1, 1'b1, 16'h8000, 5'd1,  1'b0, 1'b0};
    vec[5]  = '{1'b1, 1'b1, 16'hFF00, 5'd8,  1'b0, 1'b0};
    vec[6]  = '{1'b1, 1'b1, 16'hFFFE, 5'd15, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 1'b0, 16'h00FB, 5'd8,  1'b1, 1'b0};
    vec[8]  = '{1'b1, 1'b0, 16'h0100, 5'd0,  1'b1, 1'b0};
    vec[9]  = '{1'b1, 1'b1, 16'hDF00, 5'd8,  1'b1, 1'b0};
    vec[10] = '{1'b1, 1'b0, 16'h0003, 5'd2,  1'b0, 1'b0};
    vec[11] = '{1'b0, 1'b0, 16'hFFFF, 5'd2,  1'b0, 1'b0};
    vec[12] = '{1'b1, 1'b0, 16'h003F, 5'd6,  1'b0, 1'b0};

    drive(1'b0, 1'b0, '0);
    bus.clr_i = 1'b0;

    #2;
    check("reset valid_o", 32'(bus.valid_o), 32'd0);
    check("reset data_o", 32'(bus.data_o), 32'd0);
    check("reset bubble_o", 32'(bus.bubble_o), 32'd0);
    check("reset err_o", 32'(bus.err_o), 32'd0);
    check("reset err_cnt_o", 32'(bus.err_cnt_o), 32'd0);
    #10 rst_i = 1'b0;

    // Streaming table: the result for word t appears right after the second edge that follows it.
    for (int t = 0; t < NV + 2; t++) begin
      step();
      if (t >= 2) begin
        check($sformatf("vec%0d valid_o", t - 2), 32'(bus.valid_o), 32'(vec[t-2].v));
        check($sformatf("vec%0d data_o", t - 2), 32'(bus.data_o), 32'(vec[t-2].exp_data));
        if (vec[t-2].v) begin
          check($sformatf("vec%0d bubble_o", t - 2), 32'(bus.bubble_o), 32'(vec[t-2].exp_bub));
          check($sformatf("vec%0d err_o", t - 2), 32'(bus.err_o), 32'(vec[t-2].exp_err));
        end
      end
      if (t < NV) drive(vec[t].v, vec[t].oc, vec[t].data);
      else        drive(1'b0, 1'b0, '0);
    end
    step();
    check("no-error err_cnt_o", 32'(bus.err_cnt_o), 32'd0);

    // A single multi-bit fault: the count is the popcount and the word is flagged non-monotone.
    drive(1'b1, 1'b0, 16'h0F0F);
    step();
    drive(1'b0, 1'b0, '0);
    step();
    check("fault valid_o", 32'(bus.valid_o), 32'd1);
    check("fault data_o", 32'(bus.data_o), 32'd8);
    check("fault err_o", 32'(bus.err_o), 32'd1);
    check("fault bubble_o", 32'(bus.bubble_o), 32'd0);
    step();
    check("fault err_cnt_o", 32'(bus.err_cnt_o), 32'd1);
    check("fault valid_o drop", 32'(bus.valid_o), 32'd0);

    // 300 further faults drive the counter past its ceiling.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, 16'h0F0F);
      step();
    end
    drive(1'b0, 1'b0, '0);
    repeat (5) step();
    check("saturated err_cnt_o", 32'(bus.err_cnt_o), 32'd255);

    // Clear coincides with an error cycle and must win.
    drive(1'b1, 1'b0, 16'h0F0F);
    step();
    drive(1'b0, 1'b0, '0);
    step();
    check("clr-cycle valid_o", 32'(bus.valid_o), 32'd1);
    check("clr-cycle err_o", 32'(bus.err_o), 32'd1);
    check("pre-clr err_cnt_o", 32'(bus.err_cnt_o), 32'd255);
    bus.clr_i = 1'b1;
    step();
    bus.clr_i = 1'b0;
    check("clr err_cnt_o", 32'(bus.err_cnt_o), 32'd0);

    // Give the counter a nonzero value so that the reset below visibly clears it.
    drive(1'b1, 1'b0, 16'h0F0F);
    step();
    drive(1'b0, 1'b0, '0);
    step();
    step();
    check("pre-reset err_cnt_o", 32'(bus.err_cnt_o), 32'd1);

    // Two words in flight, then reset is asserted asynchronously between edges.
    drive(1'b1, 1'b0, 16'h0003);
    step();
    drive(1'b1, 1'b1, 16'hFF00);
    step();
    drive(1'b0, 1'b0, '0);
    #2 rst_i = 1'b1;
    #1;
    check("async rst valid_o", 32'(bus.valid_o), 32'd0);
    check("async rst data_o", 32'(bus.data_o), 32'd0);
    check("async rst bubble_o", 32'(bus.bubble_o), 32'd0);
    check("async rst err_o", 32'(bus.err_o), 32'd0);
    check("async rst err_cnt_o", 32'(bus.err_cnt_o), 32'd0);
    step();
    #2 rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("post-rst valid_o c%0d", i), 32'(bus.valid_o), 32'd0);
    end
    check("post-rst data_o", 32'(bus.data_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
